ram_dp_be: RTL
==============

RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits (a multiple of 8, minimum 8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning address width (DEPTH = 2**ADDR_WIDTH words).
REQ-003 The block SHALL have parameter RDW_MODE, default 0, meaning same-address read-during-write result (0 = old data, 1 = new data).
REQ-004 The block SHALL have port CLK_I  input  1  sole clock, all logic on the rising edge.
REQ-005 The block SHALL have port RSTN_I  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port WE_I  input  1  write request.
REQ-007 The block SHALL have port WADDR_I  input  ADDR_WIDTH  write address.
REQ-008 The block SHALL have port DATA_I  input  DATA_WIDTH  write data.
REQ-009 The block SHALL have port BE_I  input  DATA_WIDTH/8  byte enables, bit k covering DATA_I[8k+7:8k].
REQ-010 The block SHALL have port RE_I  input  1  read request.
REQ-011 The block SHALL have port RADDR_I  input  ADDR_WIDTH  read address.
REQ-012 The block SHALL have port CLR_I  input  1  request to zero the whole array.
REQ-013 The block SHALL have port DATA_O  output  DATA_WIDTH  registered read data.
REQ-014 The block SHALL have port VALID_O  output  1  DATA_O holds the result of a read accepted in the previous cycle.
REQ-015 The block SHALL have port BUSY_O  output  1  clear in progress; requests ignored.

Function
REQ-016 The block SHALL implement a two-state FSM: CLEAR and READY.
REQ-017 In CLEAR, an internal counter SHALL write all-zero to address counter each cycle, from 0 up to DEPTH-1, one address per cycle.
REQ-018 CLEAR SHALL transition to READY on the cycle the write to address DEPTH-1 is performed; a full clear takes exactly DEPTH cycles.
REQ-019 READY SHALL transition to CLEAR when CLR_I=1, with the counter restarting at 0; CLR_I in CLEAR SHALL be ignored (no restart).
REQ-020 BUSY_O SHALL equal 1 exactly while the FSM is in CLEAR.
REQ-021 In CLEAR, WE_I and RE_I SHALL be ignored: no array update, VALID_O=0.
REQ-022 In READY with WE_I=1, each byte k of word WADDR_I with BE_I[k]=1 SHALL take DATA_I byte k; bytes with BE_I[k]=0 SHALL keep their value.
REQ-023 WE_I=1 with BE_I all zero SHALL leave the array unchanged.
REQ-024 In READY with RE_I=1, DATA_O SHALL present word RADDR_I on the next cycle with VALID_O=1 (read latency 1).
REQ-025 Without an accepted read, VALID_O SHALL be 0 and DATA_O SHALL hold its last value.
REQ-026 For same-cycle read and write to the same address, DATA_O SHALL be the pre-write word if RDW_MODE=0, or the post-write word (enabled bytes new, others old) if RDW_MODE=1.
REQ-027 Read and write to different addresses in the same cycle SHALL both complete without interference.
REQ-028 CLR_I=1 together with WE_I/RE_I in READY SHALL take precedence: the write and read in that cycle SHALL be ignored, VALID_O=0 next cycle.

Reset
REQ-029 While RSTN_I=0 at a rising edge, the block SHALL set DATA_O=0, VALID_O=0, counter=0 and FSM=CLEAR (BUSY_O=1).
REQ-030 After RSTN_I is released the block SHALL perform a full DEPTH-cycle clear before accepting requests.
REQ-031 Reset asserted mid-clear or mid-operation SHALL restart the clear from address 0.
REQ-032 Array contents SHALL NOT be reset directly; zeroing SHALL occur only through CLEAR.

Verification
REQ-033 Reset, release, defaults: BUSY_O=1 for exactly 256 cycles, then 0; reads of addresses 0, 34, 255 return 0x00 with VALID_O=1 one cycle later.
REQ-034 Write 0xA5 to 105 with BE_I=1, read 105 -> DATA_O=0xA5 next cycle; with DATA_WIDTH=16, write 0x1234 BE=11 then 0xFFFF BE=01 to 20, read -> 0x12FF.
REQ-035 RDW: 227 holds 0x11, same-cycle write 0x22 and read 227 -> DATA_O=0x11 (RDW_MODE=0), 0x22 (RDW_MODE=1).
REQ-036 Fill addresses 34, 79 with 0x3C, 0xC3; pulse CLR_I -> BUSY_O=1 for 256 cycles, WE_I during clear has no effect, reads afterward return 0x00.
REQ-037 Assert RSTN_I=0 at clear counter 100 -> on release BUSY_O=1 for a fresh 256 cycles; CLR_I during CLEAR does not extend it.
REQ-038 Bench SHALL keep a reference model and compare every VALID_O=1 DATA_O over 1000 random READY-state requests with random BE_I.

Source files
------------

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, registered read data and a
// sequential zeroing engine that runs after reset and on CLR_I.
module ram_dp_be #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RDW_MODE   = 0
) (
  input  logic                    CLK_I,
  input  logic                    RSTN_I,
  input  logic                    WE_I,
  input  logic [ADDR_WIDTH-1:0]   WADDR_I,
  input  logic [DATA_WIDTH-1:0]   DATA_I,
  input  logic [DATA_WIDTH/8-1:0] BE_I,
  input  logic                    RE_I,
  input  logic [ADDR_WIDTH-1:0]   RADDR_I,
  input  logic                    CLR_I,
  output logic [DATA_WIDTH-1:0]   DATA_O,
  output logic                    VALID_O,
  output logic                    BUSY_O
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH/8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  valid_reg;
  logic                  last_addr;
  logic                  req_ok;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  clr_wr;
  logic                  same_addr;

  assign last_addr = (cnt_reg == {ADDR_WIDTH{1'b1}});

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (last_addr) state_next = READY;
      end
      READY: begin
        cnt_next = '0;
        if (CLR_I) state_next = CLEAR;
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A clear request wins over any read or write presented in the same cycle.
  assign req_ok    = RSTN_I && (state_reg == READY) && !CLR_I;
  assign wr_ok     = req_ok && WE_I;
  assign rd_ok     = req_ok && RE_I;
  assign clr_wr    = RSTN_I && (state_reg == CLEAR);
  assign same_addr = (WADDR_I == RADDR_I);

  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) valid_reg <= 1'b0;
    else         valid_reg <= rd_ok;
  end

  assign VALID_O = valid_reg;
  assign BUSY_O  = (state_reg == CLEAR);

  // One narrow array per byte lane keeps byte-enable writes BRAM-friendly.
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_lane_reg;
      logic       fwd;

      assign fwd = (RDW_MODE != 0) && wr_ok && BE_I[gi] && same_addr;

      always_ff @(posedge CLK_I) begin
        if (clr_wr)
          lane_mem[cnt_reg] <= 8'h00;
        else if (wr_ok && BE_I[gi])
          lane_mem[WADDR_I] <= DATA_I[8*gi +: 8];
      end

      always_ff @(posedge CLK_I) begin
        if (!RSTN_I)
          rd_lane_reg <= 8'h00;
        else if (rd_ok)
          rd_lane_reg <= fwd ? DATA_I[8*gi +: 8] : lane_mem[RADDR_I];
      end

      assign DATA_O[8*gi +: 8] = rd_lane_reg;
    end
  endgenerate

endmodule
